hzd_ctrl: RTL

Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It detects load-use and control hazards, and computes EX-stage operand forwarding selects. It also sequences stall/flush of every pipeline register while the MEM-stage LSU handshake is waiting, and bounds that wait with a timeout. It is the sole driver of `i_id2ex_stall`/`i_id2ex_flush` on the decode unit and of the stall/flush inputs of the fetch, IF/ID, EX/MEM and MEM/WB registers.

---
 rtl/hzd_ctrl_pkg.sv | 26 ++
 rtl/DFF_RST_EN_CLR.sv | 20 ++
 rtl/lsu_wait_fsm.sv | 58 +++++
 rtl/hzd_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/hzd_ctrl_pkg.sv
// Shared encodings for the core hazard controller: forwarding selects and LSU wait FSM states.
package hzd_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wait_state_e;

  // MEM is the youngest producer, so it is checked before WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src_idx,
    input logic [4:0] rd_m,
    input logic       rd_en_m,
    input logic [4:0] rd_w,
    input logic       rd_en_w
  );
    if (rd_en_m && (rd_m != 5'd0) && (rd_m == src_idx)) return FWD_MEM;
    if (rd_en_w && (rd_w != 5'd0) && (rd_w == src_idx)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/DFF_RST_EN_CLR.sv
// Generic register with asynchronous active-high reset, synchronous clear and enable.
module DFF_RST_EN_CLR #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/lsu_wait_fsm.sv
// Tracks how long the MEM-stage LSU has been waiting and raises a one-cycle abort on timeout.
module lsu_wait_fsm
  import hzd_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic i_lsu_req_m,
  input  logic i_lsu_ready_m,
  output logic o_mem_wait,
  output logic o_mem_timeout
);

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wait_state_e      state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // The abort cycle itself never counts as waiting, which releases the stalls.
  assign o_mem_wait    = i_lsu_req_m & ~i_lsu_ready_m & ~timeout_q;
  assign o_mem_timeout = timeout_q;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (o_mem_wait) begin
            state_q    <= WAIT;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (o_mem_wait) begin
            if (wait_cnt_q == CNT_LAST) begin
              timeout_q  <= 1'b1;
              state_q    <= RUN;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hzd_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush sequencing, EX forwarding selects,
// LSU wait timeout and a stall-cycle performance counter.
module hzd_ctrl
  import hzd_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 256,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk_sys,
  input  logic                      rst_sys,
  input  logic [4:0]                i_rs1_idx_d,
  input  logic [4:0]                i_rs2_idx_d,
  input  logic                      i_rs1_en_d,
  input  logic                      i_rs2_en_d,
  input  logic [4:0]                i_rs1idx_e,
  input  logic [4:0]                i_rs2idx_e,
  input  logic [4:0]                i_rdidx_e,
  input  logic                      i_rd_en_e,
  input  logic                      i_load_e,
  input  logic [4:0]                i_rdidx_m,
  input  logic                      i_rd_en_m,
  input  logic [4:0]                i_rdidx_w,
  input  logic                      i_rd_en_w,
  input  logic                      i_branch_taken_e,
  input  logic                      i_lsu_req_m,
  input  logic                      i_lsu_ready_m,
  output logic                      o_if_stall,
  output logic                      o_if2id_stall,
  output logic                      o_id2ex_stall,
  output logic                      o_ex2mem_stall,
  output logic                      o_if2id_flush,
  output logic                      o_id2ex_flush,
  output logic                      o_mem2wb_flush,
  output logic [1:0]                o_fwd_a_sel,
  output logic [1:0]                o_fwd_b_sel,
  output logic                      o_mem_timeout,
  output logic [PERF_CNT_WIDTH-1:0] o_stall_cycles
);

  logic mem_wait;
  logic load_use;
  logic [PERF_CNT_WIDTH-1:0] stall_cnt_d;

  lsu_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_fsm (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .i_lsu_req_m  (i_lsu_req_m),
    .i_lsu_ready_m(i_lsu_ready_m),
    .o_mem_wait   (mem_wait),
    .o_mem_timeout(o_mem_timeout)
  );

  assign load_use = i_load_e & i_rd_en_e & (i_rdidx_e != 5'd0) &
                    ((i_rs1_en_d & (i_rs1_idx_d == i_rdidx_e)) |
                     (i_rs2_en_d & (i_rs2_idx_d == i_rdidx_e)));

  // A pending redirect stays suppressed under mem_wait; the held branch level replays it on release.
  always_comb begin
    o_if_stall     = 1'b0;
    o_if2id_stall  = 1'b0;
    o_id2ex_stall  = 1'b0;
    o_ex2mem_stall = 1'b0;
    o_if2id_flush  = 1'b0;
    o_id2ex_flush  = 1'b0;
    o_mem2wb_flush = 1'b0;
    o_fwd_a_sel    = FWD_RF;
    o_fwd_b_sel    = FWD_RF;
    if (rst_sys) begin
      o_if2id_flush  = 1'b1;
      o_id2ex_flush  = 1'b1;
      o_mem2wb_flush = 1'b1;
    end else begin
      if (mem_wait) begin
        o_if_stall     = 1'b1;
        o_if2id_stall  = 1'b1;
        o_id2ex_stall  = 1'b1;
        o_ex2mem_stall = 1'b1;
        o_mem2wb_flush = 1'b1;
      end else begin
        o_mem2wb_flush = o_mem_timeout;
        if (i_branch_taken_e) begin
          o_if2id_flush = 1'b1;
          o_id2ex_flush = 1'b1;
        end else if (load_use) begin
          o_if_stall    = 1'b1;
          o_if2id_stall = 1'b1;
          o_id2ex_flush = 1'b1;
        end
      end
      o_fwd_a_sel = fwd_sel(i_rs1idx_e, i_rdidx_m, i_rd_en_m, i_rdidx_w, i_rd_en_w);
      o_fwd_b_sel = fwd_sel(i_rs2idx_e, i_rdidx_m, i_rd_en_m, i_rdidx_w, i_rd_en_w);
    end
  end

  assign stall_cnt_d = o_stall_cycles + PERF_CNT_WIDTH'(1);

  DFF_RST_EN_CLR #(
    .W      (PERF_CNT_WIDTH),
    .RST_VAL('0)
  ) u_stall_cnt (
    .clk(clk_sys),
    .rst(rst_sys),
    .en (o_if_stall),
    .clr(1'b0),
    .d  (stall_cnt_d),
    .q  (o_stall_cycles)
  );

endmodule
